gpio_bank: RTL and testbench

Parametrised multi-channel memory-mapped GPIO peripheral for the single-cycle/pipelined processor's data bus. It is the successor to the fixed two-port GPIO block. It provides NCH channels of WIDTH-bit outputs and inputs, a configurable input synchroniser, and per-bit change detection with sticky write-1-to-clear status. Per-channel interrupt enables are combined into one level interrupt for the processor.

---
 rtl/gpio_bank_pkg.sv | 20 ++
 rtl/gpio_bank_if.sv | 16 +
 rtl/gpio_sync.sv | 28 ++
 rtl/gpio_bank.sv | 119 +++++++++++
 tb/tb_gpio_bank.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets and address-width helper.
// Software headers mirror the same register offsets.
package gpio_bank_pkg;

  // Register offsets within a channel, selected by A[1:0]
  typedef enum logic [1:0] {
    REG_OUT   = 2'd0,
    REG_IN    = 2'd1,
    REG_IEN   = 2'd2,
    REG_ISTAT = 2'd3
  } gpio_reg_e;

  // Word-address width: two register-select bits plus channel-select bits, never below 3
  function automatic int calc_aw(input int nch);
    int aw;
    aw = 2 + $clog2(nch);
    return (aw < 3) ? 3 : aw;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Data-bus port of the GPIO bank.
// Bus semantics: there is no valid/ready pair. A write commits on the rising
// clk edge where WE=1 (the slave is always ready); RD is combinational from A
// and the current register state, so a read completes in the same cycle.
interface gpio_bank_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 32
) ();
  logic [AW-1:0]    A;
  logic             WE;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] RD;

  modport master (output A, output WE, output WD, input RD);
  modport slave  (input A, input WE, input WD, output RD);
endinterface

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser for one WIDTH-bit channel.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Multi-channel memory-mapped GPIO: output registers, synchronised inputs,
// per-bit change detection with sticky W1C status and a combined level irq.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NCH         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = calc_aw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_bank_if.slave           bus,
  input  logic [NCH*WIDTH-1:0] gpI,
  output logic [NCH*WIDTH-1:0] gpO,
  output logic                 irq
);

  localparam int CW = AW - 2;

  logic [CW-1:0]    ch_sel;
  gpio_reg_e        reg_sel;
  logic             ch_valid;
  logic [WIDTH-1:0] rd_w;
  logic [NCH-1:0]   irq_ch;

  logic [WIDTH-1:0] out_w   [NCH];
  logic [WIDTH-1:0] in_w    [NCH];
  logic [WIDTH-1:0] ien_w   [NCH];
  logic [WIDTH-1:0] istat_w [NCH];

  assign ch_sel   = bus.A[AW-1:2];
  assign reg_sel  = gpio_reg_e'(bus.A[1:0]);
  // Channel indices past NCH (non power-of-two NCH) decode to nothing
  assign ch_valid = (32'(ch_sel) < 32'(NCH));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam logic [CW-1:0] CH_IDX = CW'(c);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] istat_q, istat_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_w, change, clr_mask;
    logic             wr_sel;

    gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (gpI[c*WIDTH +: WIDTH]),
      .q   (sync_w)
    );

    assign wr_sel = bus.WE && ch_valid && (ch_sel == CH_IDX);
    assign change = sync_w ^ prev_q;

    // Next-state for the channel registers; a new set beats a same-cycle W1C
    always_comb begin
      out_d    = out_q;
      ien_d    = ien_q;
      clr_mask = '0;
      if (wr_sel) begin
        case (reg_sel)
          REG_OUT:   out_d    = bus.WD;
          REG_IN:    ;
          REG_IEN:   ien_d    = bus.WD;
          REG_ISTAT: clr_mask = bus.WD;
          default:   ;
        endcase
      end
      istat_d = (istat_q & ~clr_mask) | (change & ien_q);
    end

    // Channel state; prev tracks the synchroniser output every cycle
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_q   <= '0;
        ien_q   <= '0;
        istat_q <= '0;
        prev_q  <= '0;
      end else begin
        out_q   <= out_d;
        ien_q   <= ien_d;
        istat_q <= istat_d;
        prev_q  <= sync_w;
      end
    end

    assign out_w[c]   = out_q;
    assign in_w[c]    = sync_w;
    assign ien_w[c]   = ien_q;
    assign istat_w[c] = istat_q;
    assign irq_ch[c]  = |(istat_q & ien_q);
    assign gpO[c*WIDTH +: WIDTH] = out_q;
  end

  // Read mux: combinational from the pre-edge register state
  always_comb begin
    rd_w = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_valid && (ch_sel == CW'(c))) begin
        case (reg_sel)
          REG_OUT:   rd_w = out_w[c];
          REG_IN:    rd_w = in_w[c];
          REG_IEN:   rd_w = ien_w[c];
          REG_ISTAT: rd_w = istat_w[c];
          default:   rd_w = '0;
        endcase
      end
    end
  end

  assign bus.RD = rd_w;
  assign irq    = |irq_ch;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed testbench for gpio_bank with NCH=3 so the unused channel index 3 is decodable.
module tb_gpio_bank;
  import gpio_bank_pkg::*;

  localparam int WIDTH = 32;
  localparam int NCH   = 3;
  localparam int SS    = 2;
  localparam int AW    = calc_aw(NCH);

  // Clock and reset
  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] gpI;
  logic [NCH*WIDTH-1:0] gpO;
  logic                 irq;

  int errors = 0;
  int checks = 0;

  gpio_bank_if #(.AW(AW), .WIDTH(WIDTH)) bus_if ();

  gpio_bank #(
    .WIDTH       (WIDTH),
    .NCH         (NCH),
    .SYNC_STAGES (SS),
    .AW          (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave),
    .gpI (gpI),
    .gpO (gpO),
    .irq (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // Driver tasks
  function automatic logic [AW-1:0] addr(input int ch, input gpio_reg_e r);
    return {(AW-2)'(ch), 2'(r)};
  endfunction

  task automatic bus_write(input int ch, input gpio_reg_e r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus_if.A  = addr(ch, r);
    bus_if.WE = 1'b1;
    bus_if.WD = d;
    @(negedge clk);
    bus_if.WE = 1'b0;
  endtask

  task automatic bus_read(input int ch, input gpio_reg_e r, output logic [WIDTH-1:0] d);
    bus_if.A = addr(ch, r);
    #1;
    d = bus_if.RD;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] rd;
    rst = 1'b0;
    gpI = '1;
    repeat (3) @(negedge clk);
    checks++; if (gpO !== '0) begin errors++; $display("FAIL reset_gpo: got %h want 0", gpO); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_in: got %h want %h", rd, 32'h0); end
    rst = 1'b1;
    @(negedge clk);
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL in_after_1_edge: got %h want %h", rd, 32'h0); end
    @(negedge clk);
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL in_after_2_edges: got %h want %h", rd, 32'hFFFF_FFFF); end
    bus_read(2, REG_IN, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL in_ch2_after_reset: got %h want %h", rd, 32'hFFFF_FFFF); end
    repeat (2) @(negedge clk);
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_istat: got %h want %h", rd, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after_release: got %b want 0", irq); end
    gpI = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_output_write();
    logic [WIDTH-1:0] rd;
    @(negedge clk);
    bus_if.A  = addr(1, REG_OUT);
    bus_if.WE = 1'b1;
    bus_if.WD = 32'hA5A5_0F0F;
    #1;
    checks++; if (bus_if.RD !== 32'h0) begin errors++; $display("FAIL read_during_write: got %h want %h", bus_if.RD, 32'h0); end
    checks++; if (gpO !== '0) begin errors++; $display("FAIL gpo_before_edge: got %h want 0", gpO); end
    @(negedge clk);
    bus_if.WE = 1'b0;
    checks++; if (gpO !== {32'h0, 32'hA5A5_0F0F, 32'h0}) begin errors++; $display("FAIL gpo_ch1_write: got %h want %h", gpO, {32'h0, 32'hA5A5_0F0F, 32'h0}); end
    bus_read(1, REG_OUT, rd);
    checks++; if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL out_ch1_readback: got %h want %h", rd, 32'hA5A5_0F0F); end
    bus_read(0, REG_OUT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL out_ch0_unchanged: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_change_detect();
    logic [WIDTH-1:0] rd;
    bus_write(0, REG_IEN, 32'h1);
    bus_read(0, REG_IEN, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ien_readback: got %h want %h", rd, 32'h1); end
    gpI[0] = 1'b1;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_edge_k: got %b want 0", irq); end
    @(negedge clk);
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL in_latency: got %h want %h", rd, 32'h1); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_edge_k1: got %b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_edge_k2: got %b want 1", irq); end
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL istat_set: got %h want %h", rd, 32'h1); end
    gpI[1] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL istat_bit1_masked: got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_w1c_race();
    logic [WIDTH-1:0] rd;
    gpI[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_if.A  = addr(0, REG_ISTAT);
    bus_if.WE = 1'b1;
    bus_if.WD = 32'h1;
    @(negedge clk);
    bus_if.WE = 1'b0;
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL w1c_race_istat: got %h want %h", rd, 32'h1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_race_irq: got %b want 1", irq); end
    bus_write(0, REG_ISTAT, 32'h1);
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear_istat: got %h want %h", rd, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear_irq: got %b want 0", irq); end
  endtask

  task automatic test_decode_mask();
    logic [WIDTH-1:0] rd;
    bus_read(3, REG_OUT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ch3_read: got %h want %h", rd, 32'h0); end
    bus_write(3, REG_OUT, 32'hFFFF_FFFF);
    bus_write(3, REG_IEN, 32'hFFFF_FFFF);
    checks++; if (gpO !== {32'h0, 32'hA5A5_0F0F, 32'h0}) begin errors++; $display("FAIL ch3_write_ignored: got %h want %h", gpO, {32'h0, 32'hA5A5_0F0F, 32'h0}); end
    bus_read(3, REG_IEN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ch3_ien_read: got %h want %h", rd, 32'h0); end
    bus_read(1, REG_IEN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ch3_no_alias_ien: got %h want %h", rd, 32'h0); end
    bus_write(0, REG_IN, 32'hDEAD_BEEF);
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL in_write_ignored: got %h want %h", rd, 32'h2); end
    bus_write(2, REG_IEN, 32'h20);
    gpI[2*WIDTH+5] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ch2_irq_set: got %b want 1", irq); end
    bus_write(2, REG_IEN, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ien_mask_irq: got %b want 0", irq); end
    bus_read(2, REG_ISTAT, rd);
    checks++; if (rd !== 32'h20) begin errors++; $display("FAIL ien_mask_istat_kept: got %h want %h", rd, 32'h20); end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] rd;
    bus_write(2, REG_IEN, 32'h20);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reenable_irq: got %b want 1", irq); end
    bus_read(0, REG_ISTAT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL no_retro_capture: got %h want %h", rd, 32'h0); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq: got %b want 0", irq); end
    checks++; if (gpO !== '0) begin errors++; $display("FAIL async_rst_gpo: got %h want 0", gpO); end
    bus_read(0, REG_IN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL async_rst_in: got %h want %h", rd, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(2, REG_ISTAT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_rst_istat: got %h want %h", rd, 32'h0); end
    bus_read(1, REG_OUT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL post_rst_out: got %h want %h", rd, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_rst_irq: got %b want 0", irq); end
  endtask

  // Test sequence and final report
  initial begin
    rst       = 1'b0;
    gpI       = '1;
    bus_if.A  = '0;
    bus_if.WE = 1'b0;
    bus_if.WD = '0;
    test_reset();
    test_output_write();
    test_change_detect();
    test_w1c_race();
    test_decode_mask();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
